line_sched: RTL

Sequencer for the Gaussian convolution / peak-search engine (`convmax`). It accepts laser-scan lines as a byte stream into a two-entry ping-pong line buffer and holds the Gaussian kernel half in registers. It starts the engine once per complete line and pushes each line's `{line index, peak position, peak value}` into a result FIFO read by the host-facing Avalon wrapper. Filling of one buffer overlaps engine processing of the other.

---
 rtl/line_sched_pkg.sv | 21 ++
 rtl/line_sched_res_fifo.sv | 47 ++++
 rtl/line_sched.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/line_sched_pkg.sv
// line_sched shared types: engine FSM states and the result word layout.
// Defaults for line length, kernel taps, FIFO depth and watchdog limit.
package line_sched_pkg;
  localparam int DEF_PIXELS = 144;
  localparam int DEF_GAUSS_TAPS = 8;
  localparam int DEF_RES_DEPTH = 4;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

  typedef enum logic [1:0] {
    E_IDLE,
    E_START,
    E_WAIT,
    E_PUSH
  } eng_state_t;

  typedef struct packed {
    logic [7:0]  idx;
    logic [7:0]  maxpos;
    logic [15:0] maxval;
  } line_result_t;
endpackage

// File: rtl/line_sched_res_fifo.sv
// Result FIFO with first-word-fall-through output.
// A push while full succeeds when a pop happens in the same cycle.
module res_fifo
  import line_sched_pkg::*;
#(
  parameter int DEPTH = DEF_RES_DEPTH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  line_result_t din,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output line_result_t dout
);
  localparam int AW = $clog2(DEPTH);

  line_result_t mem [DEPTH];
  logic [AW-1:0] rd;
  logic [AW-1:0] wr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign out_valid = cnt != '0;
  assign do_pop    = out_valid && out_ready;
  assign in_ready  = (cnt != (AW+1)'(DEPTH)) || do_pop;
  assign do_push   = push && in_ready;
  assign dout      = mem[rd];

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd  <= '0;
      wr  <= '0;
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr] <= din;
        wr      <= wr + 1'b1;
      end
      if (do_pop) rd <= rd + 1'b1;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/line_sched.sv
// Ping-pong line buffer sequencer for the convmax engine.
// Define LINE_SCHED_TIMEOUT_EN to enable the E_WAIT watchdog.
module line_sched
  import line_sched_pkg::*;
#(
  parameter int PIXELS = DEF_PIXELS,
  parameter int GAUSS_TAPS = DEF_GAUSS_TAPS,
  parameter int RES_DEPTH = DEF_RES_DEPTH
`ifdef LINE_SCHED_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [7:0]              load_data,
  input  logic                    load_sof,
  input  logic                    load_last,
  input  logic                    gauss_we,
  input  logic [2:0]              gauss_addr,
  input  logic [7:0]              gauss_data,
  output logic [PIXELS*8-1:0]     eng_indata,
  output logic [GAUSS_TAPS*8-1:0] eng_gauss,
  output logic                    eng_start,
  input  logic                    eng_done,
  input  logic [15:0]             eng_maxval,
  input  logic [7:0]              eng_maxpos,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [31:0]             res_data,
  output logic                    busy,
  output logic                    len_err,
  output logic                    cfg_err,
  output logic                    timeout
);
  localparam int WW = $clog2(PIXELS);

  logic [7:0]    buf_mem [2][PIXELS];
  logic [7:0]    gauss [GAUSS_TAPS];
  logic [7:0]    tag [2];
  logic [1:0]    full;
  logic [1:0]    full_nxt;
  logic [WW-1:0] wptr;
  logic          fsel;
  logic          esel;
  logic [7:0]    line_idx;
  eng_state_t    state;
  line_result_t  cap;
  line_result_t  res_dout;
  logic          push;
  logic          push_ok;
  logic          accept;
  logic          at_end;

  assign load_ready = reset && !full[fsel];
  assign accept     = load_valid && load_ready;
  assign at_end     = wptr == WW'(PIXELS-1);
  assign busy       = state != E_IDLE;
  assign push       = state == E_PUSH;
  assign res_data   = res_dout;

  always_comb begin
    eng_indata = '0;
    eng_gauss  = '0;
    for (int i = 0; i < PIXELS; i++) eng_indata[i*8 +: 8] = buf_mem[esel][i];
    for (int i = 0; i < GAUSS_TAPS; i++) eng_gauss[i*8 +: 8] = gauss[i];
  end

  // Release is applied before set so a refill of the released slot wins.
  always_comb begin
    full_nxt = full;
    if (push && push_ok) full_nxt[esel] = 1'b0;
    if (accept && at_end) full_nxt[fsel] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) full <= '0;
    else full <= full_nxt;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr     <= '0;
      fsel     <= 1'b0;
      line_idx <= '0;
      len_err  <= 1'b0;
      tag[0]   <= '0;
      tag[1]   <= '0;
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < PIXELS; i++) buf_mem[b][i] <= '0;
    end else if (accept) begin
      buf_mem[fsel][wptr] <= load_data;
      if (load_last != at_end) len_err <= 1'b1;
      if (at_end) begin
        tag[fsel] <= load_sof ? 8'd0 : line_idx;
        line_idx  <= load_sof ? 8'd1 : line_idx + 8'd1;
        fsel      <= !fsel;
        wptr      <= '0;
      end else begin
        wptr <= wptr + 1'b1;
        if (load_sof) line_idx <= 8'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cfg_err <= 1'b0;
      for (int i = 0; i < GAUSS_TAPS; i++) gauss[i] <= '0;
    end else if (gauss_we) begin
      if (busy) cfg_err <= 1'b1;
      else if (32'(gauss_addr) < GAUSS_TAPS) gauss[gauss_addr] <= gauss_data;
    end
  end

`ifdef LINE_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] tcnt;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= E_IDLE;
      esel      <= 1'b0;
      eng_start <= 1'b0;
      cap       <= '0;
`ifdef LINE_SCHED_TIMEOUT_EN
      tcnt      <= '0;
      timeout   <= 1'b0;
`endif
    end else begin
      eng_start <= 1'b0;
      unique case (state)
        E_IDLE: begin
          if (full[esel]) begin
            state     <= E_START;
            eng_start <= 1'b1;
          end
        end
        E_START: begin
          state <= E_WAIT;
`ifdef LINE_SCHED_TIMEOUT_EN
          tcnt  <= TW'(1);
`endif
        end
        E_WAIT: begin
          if (eng_done) begin
            cap.idx    <= tag[esel];
            cap.maxpos <= eng_maxpos;
            cap.maxval <= eng_maxval;
            state      <= E_PUSH;
          end
`ifdef LINE_SCHED_TIMEOUT_EN
          else if (tcnt == TW'(TIMEOUT_CYCLES-1)) begin
            timeout    <= 1'b1;
            cap.idx    <= tag[esel];
            cap.maxpos <= 8'hFF;
            cap.maxval <= 16'hFFFF;
            state      <= E_PUSH;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
`endif
        end
        E_PUSH: begin
          if (push_ok) begin
            state <= E_IDLE;
            esel  <= !esel;
          end
        end
        default: state <= E_IDLE;
      endcase
    end
  end

  res_fifo #(.DEPTH(RES_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .din       (cap),
    .in_ready  (push_ok),
    .out_valid (res_valid),
    .out_ready (res_ready),
    .dout      (res_dout)
  );
endmodule
